// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Purpose:
//   Synchronises one raw, asynchronous, bouncy push-button pin into the clk
//   domain and debounces it. It produces a clean pressed level,
//   single-cycle press/release/long-press strobes and a wrapping press counter.
//   Downstream logic uses only these outputs and never the raw pin.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronised cycles needed to accept
//                     a level change (>= 1)
//   LONG_CYCLES     : cycles spent pressed, counted from press_pulse, before
//                     long_pulse fires (>= 1)
//   ACTIVE_HIGH     : 1 -> pin high means pressed, 0 -> pin low means pressed
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous assert, active-low reset
//   btn_in        in   raw button pin (asynchronous, may bounce)
//   btn_level     out  debounced pressed state (1 = pressed)
//   press_pulse   out  one-cycle strobe on an accepted press
//   release_pulse out  one-cycle strobe on an accepted release
//   long_pulse    out  one-cycle strobe once a press has lasted LONG_CYCLES
//   press_cnt     out  count of accepted presses, wraps 255 -> 0
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int LONG_CYCLES     = 100000,
    parameter bit ACTIVE_HIGH     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_cnt
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic              PIN_IDLE = ACTIVE_HIGH ? 1'b0 : 1'b1;
    localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    typedef enum logic [1:0] {
        S_RELEASED    = 2'd0,
        S_PRESS_CHK   = 2'd1,
        S_PRESSED     = 2'd2,
        S_RELEASE_CHK = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser. Both flops reset to the idle pin level so that a
    // button held through reset is seen as a fresh press afterwards.
    // -------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Normalised pressed indication: 1 means the pin reads "pressed".
    assign a = ACTIVE_HIGH ? sync2_q : ~sync2_q;

    // -------------------------------------------------------------------------
    // Debounce FSM state and counters
    // -------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [HOLD_W-1:0]  hold_q,      hold_d;
    logic               level_q,     level_d;
    logic               press_q,     press_d;
    logic               release_q,   release_d;
    logic               long_q,      long_d;
    logic [7:0]         press_cnt_q, press_cnt_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [HOLD_W-1:0]  hold_inc;
    logic               mismatch;
    logic               accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RELEASED;
            cnt_q       <= '0;
            hold_q      <= '0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        press_cnt_d = press_cnt_q;

        // The mismatch counter never exceeds DEB_MAX-1 while a check is in
        // progress, so the increment cannot overflow CNT_W bits.
        cnt_inc  = cnt_q + CNT_W'(1);
        hold_inc = hold_q + HOLD_W'(1);
        mismatch = (a != level_q);
        // Acceptance happens on the edge that would bring the streak to
        // DEBOUNCE_CYCLES; with DEBOUNCE_CYCLES == 1 that is the very first
        // mismatching cycle, straight out of a settled state.
        accept   = mismatch && (cnt_inc == DEB_MAX);

        // Any matching cycle restarts the streak; acceptance also clears it
        // because the accepted level now matches.
        if (!mismatch || accept) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end

        unique case (state_q)
            S_RELEASED, S_PRESS_CHK: begin
                if (accept) begin
                    state_d     = S_PRESSED;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                    hold_d      = '0;
                end else if (mismatch) begin
                    state_d = S_PRESS_CHK;
                end else begin
                    state_d = S_RELEASED;
                end
            end

            S_PRESSED, S_RELEASE_CHK: begin
                if (accept) begin
                    // Release wins over a coincident long-press strobe.
                    state_d   = S_RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else begin
                    state_d = mismatch ? S_RELEASE_CHK : S_PRESSED;
                    // Hold timer keeps running through release checks and
                    // saturates, so long_pulse fires at most once per press.
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_inc;
                        if (hold_inc == HOLD_MAX) begin
                            long_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_RELEASED;
            end
        endcase
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign press_cnt     = press_cnt_q;

endmodule
